chick_datapath: RTL and testbench
=================================

# chick_datapath

Datapath and game-state responder for the Chicken Cha-Cha-Cha controller. It consumes the controller's state code `M`, card-wait flag `A`, move phase `B` and player count `N`. It returns the `c` (start), `go` (card matches tile) and `win` handshakes the controller branches on. It also holds player positions, the turn pointer and the card-to-picture mapping, and exports display values.

## Interface
- `WIN_STEPS`, default 16: successful moves a player needs to win; legal range 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  start button, asynchronous; synchronized internally.
- `key`  in  4  keypad code; 0 means no key; 1..15 select a card.
- `M`  in  3  controller state code.
- `A`  in  1  controller is waiting for a card pick; status only.
- `B`  in  1  controller is in the move/win-check phase (`M`=110).
- `N`  in  2  player count: 2 means 2, 3 means 3, 0 means 4; 1 is illegal and treated as 2.
- `c`  out  1  synchronized start level to the controller.
- `go`  out  1  the latched card picture matches the tile ahead of the current player.
- `win`  out  1  the current player has reached `WIN_STEPS`.
- `cur_player`  out  2  index of the player whose turn it is.
- `cur_pos`  out  4  board position of the current player.
- `card_pic`  out  3  picture of the last picked card, for display.

## Operation
- The board is a ring of 16 tiles with fixed 3-bit pictures held in `TILE_PIC[0..15]`.
- Player p starts at position 4·p. Every player starts with a step count of 0.
- Card picture is `key[2:0] ^ seed[2:0]`. `seed` is 0 unless shuffle is compiled in.
- Legal player indices run from 0 to P−1, where P is the decoded value of `N`.
- State codes are 000 IDLE, 001 SETUP, 010 START, 011 PICK, 100 JUDGE, 101 MISS, 110 MOVE, 111 END.
- Actions per rising edge:
  - `M`=000: initialize positions and steps; `cur_player`←0; `go`←0; `win`←0.
  - `M`=011 with `key`≠0:
    - latch `card_pic`;
    - `go` ← (`card_pic` == `TILE_PIC[(pos+1) mod 16]`), computed from the incoming key, for the current player.
  - `M`=100 with `go`=1:
    - position ← (position+1) mod 16, wrapping 15→0;
    - steps ← steps+1, saturating at 255;
    - `win` ← (new steps ≥ `WIN_STEPS`).
  - `M`=100 with `go`=0: no change.
  - `M`=101: `cur_player` ← (`cur_player`+1) mod P; `go`←0.
  - `M`=110 with `win`=0: `go`←0. The same player keeps the turn.
  - `M`=111: all state holds; `win` stays 1 until `M` returns to 000.
- `key`≠0 outside state 011 is ignored.
- Key 8 maps to the same picture as key 0 would. This is legal; cards 1..15 reuse the 8 pictures.
- If `N` changes mid-game and `cur_player` ≥ new P, the next advance wraps to 0.
- Asserting `rst` at any time clears all registers immediately, mid-turn included.

## Timing
- Reset values: `c`=0, `go`=0, `win`=0, `cur_player`=0, `card_pic`=0, `cur_pos`=0.
- After reset, positions are 0,4,8,12, steps are 0, and `seed`=0.
- `start` path: 2-flop synchronizer; `c` follows `start` with 2 cycles of latency.
- `go` is registered on the edge that leaves PICK. It is therefore stable for the whole JUDGE cycle in which the controller samples it.
- `win` is registered on the edge that leaves JUDGE. It is stable during MOVE, when `B`=1 and the controller samples it.
- `cur_pos` is combinational from registered `cur_player` and the position array.

## Configuration
- `CHICK_SHUFFLE_EN` defined:
  - an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, seed 0x01) free-runs from reset;
  - `seed` ← LFSR value on each edge where `M`=000 and `c`=1, so the card mapping differs per game.
- `CHICK_SHUFFLE_EN` undefined: no LFSR exists and `seed` is constant 0, giving identity mapping `card_pic`=`key[2:0]`.

## Structure
- Package `chick_pkg` holds:
  - the state-code constants for 000..111;
  - `BOARD_LEN`=16;
  - the `TILE_PIC` array;
  - the player start offsets;
  - the picture width of 3 bits.
- The controller shares the same `chick_pkg` state constants.
- One sub-module, `chick_lfsr8`, is instantiated only under `CHICK_SHUFFLE_EN`.

## Test plan
- Reset and start:
  - Pulse `rst` low mid-game → all outputs reset, positions 0/4/8/12.
  - Raise `start` → `c`=1 on the 2nd edge after.
- Match:
  - Setup: no shuffle, `TILE_PIC[1]`=5, player 0 at 0.
  - Stimulus: `M`=011, `key`=5 → `go`=1 in JUDGE; `card_pic`=5.
  - Then `M`=100 → position 1, steps 1.
- Miss and rotation:
  - `N`=3, `cur_player`=2, `go`=0, `M`=101 → `cur_player`=0.
  - `N`=0, `cur_player`=3, `M`=101 → `cur_player`=0.
- Wrap: player 3 at 15 matches → position 0; next compare uses `TILE_PIC[1]`.
- Win:
  - Setup: `WIN_STEPS`=2; player 0 makes two consecutive matches.
  - Response: `win`=1 during the second MOVE; it holds through `M`=111 and clears at `M`=000.
- Shuffle (`CHICK_SHUFFLE_EN`): start at a known cycle count → `card_pic` = `key[2:0]` XOR the LFSR value captured at start.

Source files
------------

// File: rtl/chick_pkg.sv
// Shared constants for the Chicken Cha-Cha-Cha controller and datapath:
// state codes, board geometry, tile pictures and player start offsets.
package chick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SETUP = 3'b001,
    ST_START = 3'b010,
    ST_PICK  = 3'b011,
    ST_JUDGE = 3'b100,
    ST_MISS  = 3'b101,
    ST_MOVE  = 3'b110,
    ST_END   = 3'b111
  } state_e;

  localparam int BOARD_LEN       = 16;
  localparam int PIC_W           = 3;
  localparam int NUM_PLAYERS_MAX = 4;

  typedef logic [PIC_W-1:0] pic_t;
  typedef logic [3:0]       pos_t;

  localparam pic_t TILE_PIC [BOARD_LEN] = '{
    3'd2, 3'd5, 3'd1, 3'd7, 3'd0, 3'd3, 3'd6, 3'd4,
    3'd1, 3'd2, 3'd7, 3'd5, 3'd3, 3'd0, 3'd4, 3'd6
  };

  localparam pos_t START_POS [NUM_PLAYERS_MAX] = '{4'd0, 4'd4, 4'd8, 4'd12};

  // N=1 is illegal and falls back to two players.
  function automatic logic [2:0] decode_players(input logic [1:0] n);
    case (n)
      2'd3:    return 3'd3;
      2'd0:    return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/chick_if.sv
// Controller <-> datapath handshake: state code and status in, c/go/win back.
interface chick_if;
  import chick_pkg::*;

  state_e     M;
  logic       A;
  logic       B;
  logic [1:0] N;
  logic       c;
  logic       go;
  logic       win;

  modport master (output M, A, B, N, input c, go, win);
  modport slave  (input M, A, B, N, output c, go, win);

endinterface

// File: rtl/chick_lfsr8.sv
// Free-running 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1), seeded with 0x01.
module chick_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value <= 8'h01;
    else      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
  end

endmodule

// File: rtl/chick_datapath.sv
// Game-state datapath for the Chicken Cha-Cha-Cha controller.
// Define CHICK_SHUFFLE_EN to reseed the card-to-picture mapping at each game start.
module chick_datapath
  import chick_pkg::*;
#(
  parameter int WIN_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] key,
  chick_if.slave     ctl,
  output logic [1:0] cur_player,
  output pos_t       cur_pos,
  output pic_t       card_pic
);

  localparam logic [7:0] WIN_TH = 8'(WIN_STEPS);

  logic       sync1, sync2;
  pos_t       pos   [NUM_PLAYERS_MAX];
  logic [7:0] steps [NUM_PLAYERS_MAX];
  logic [7:0] seed;
  logic [2:0] num_players;
  logic [2:0] next_player;
  pic_t       pick_pic;
  pos_t       ahead;
  logic [7:0] next_steps;
  logic       unused_status;

  assign unused_status = ^{ctl.A, ctl.B, seed[7:PIC_W]};

  assign num_players = decode_players(ctl.N);
  assign next_player = {1'b0, cur_player} + 3'd1;
  assign pick_pic    = key[PIC_W-1:0] ^ seed[PIC_W-1:0];
  // 4-bit position arithmetic wraps 15 -> 0 on the 16-tile ring.
  assign ahead       = pos[cur_player] + 4'd1;
  assign next_steps  = (steps[cur_player] == 8'hFF) ? 8'hFF : steps[cur_player] + 8'd1;
  assign cur_pos     = pos[cur_player];
  assign ctl.c       = sync2;

`ifdef CHICK_SHUFFLE_EN
  logic [7:0] lfsr_value;

  chick_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             seed <= '0;
    else if (ctl.M == ST_IDLE && sync2)   seed <= lfsr_value;
  end
`else
  assign seed = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      ctl.go     <= 1'b0;
      ctl.win    <= 1'b0;
      cur_player <= '0;
      card_pic   <= '0;
      for (int p = 0; p < NUM_PLAYERS_MAX; p++) begin
        pos[p]   <= START_POS[p];
        steps[p] <= '0;
      end
    end else begin
      sync1 <= start;
      sync2 <= sync1;
      case (ctl.M)
        ST_IDLE: begin
          ctl.go     <= 1'b0;
          ctl.win    <= 1'b0;
          cur_player <= '0;
          for (int p = 0; p < NUM_PLAYERS_MAX; p++) begin
            pos[p]   <= START_POS[p];
            steps[p] <= '0;
          end
        end
        ST_PICK: begin
          if (key != 4'd0) begin
            card_pic <= pick_pic;
            ctl.go   <= (pick_pic == TILE_PIC[ahead]);
          end
        end
        ST_JUDGE: begin
          if (ctl.go) begin
            pos[cur_player]   <= ahead;
            steps[cur_player] <= next_steps;
            ctl.win           <= (next_steps >= WIN_TH);
          end
        end
        ST_MISS: begin
          // A player index left out of range by an N change wraps to 0.
          cur_player <= (next_player < num_players) ? next_player[1:0] : 2'd0;
          ctl.go     <= 1'b0;
        end
        ST_MOVE: begin
          if (!ctl.win) ctl.go <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chick_datapath.sv
// Self-checking bench for chick_datapath: directed literal scenarios plus
// randomized controller traffic compared every cycle against a game-rule model.
module tb_chick_datapath;
  import chick_pkg::*;

  localparam int TB_WIN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] key = 4'd0;
  logic [1:0] cur_player;
  logic [3:0] cur_pos;
  logic [2:0] card_pic;

  chick_if bus ();

  chick_datapath #(.WIN_STEPS(TB_WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .ctl        (bus),
    .cur_player (cur_player),
    .cur_pos    (cur_pos),
    .card_pic   (card_pic)
  );

  always #5 clk = ~clk;

  // Independent copy of the board pictures.
  int tile [16] = '{2, 5, 1, 7, 0, 3, 6, 4, 1, 2, 7, 5, 3, 0, 4, 6};

  int m_pos [4];
  int m_steps [4];
  int m_cur, m_go, m_win, m_card, m_seed, m_s1, m_c, m_lfsr;
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  function automatic int players(input logic [1:0] n);
    if (n == 2'd3) return 3;
    if (n == 2'd0) return 4;
    return 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pos[i]   = 4 * i;
      m_steps[i] = 0;
    end
    m_cur = 0; m_go = 0; m_win = 0; m_card = 0;
    m_seed = 0; m_s1 = 0; m_c = 0; m_lfsr = 1;
  endtask

  task automatic model_step();
    int p;
    int pic;
    int old_c;
    int old_lfsr;
    p        = players(bus.N);
    old_c    = m_c;
    old_lfsr = m_lfsr;
    m_c      = m_s1;
    m_s1     = int'(start);
    m_lfsr   = ((old_lfsr * 2) % 256) +
               (((old_lfsr >> 7) ^ (old_lfsr >> 5) ^ (old_lfsr >> 4) ^ (old_lfsr >> 3)) & 1);
    case (bus.M)
      ST_IDLE: begin
        for (int i = 0; i < 4; i++) begin
          m_pos[i]   = 4 * i;
          m_steps[i] = 0;
        end
        m_cur = 0; m_go = 0; m_win = 0;
`ifdef CHICK_SHUFFLE_EN
        if (old_c != 0) m_seed = old_lfsr;
`endif
      end
      ST_PICK: begin
        if (key != 4'd0) begin
          pic    = (int'(key) % 8) ^ (m_seed % 8);
          m_card = pic;
          m_go   = (pic == tile[(m_pos[m_cur] + 1) % 16]) ? 1 : 0;
        end
      end
      ST_JUDGE: begin
        if (m_go != 0) begin
          m_pos[m_cur] = (m_pos[m_cur] + 1) % 16;
          if (m_steps[m_cur] < 255) m_steps[m_cur] = m_steps[m_cur] + 1;
          m_win = (m_steps[m_cur] >= TB_WIN) ? 1 : 0;
        end
      end
      ST_MISS: begin
        m_cur = (m_cur + 1 < p) ? m_cur + 1 : 0;
        m_go  = 0;
      end
      ST_MOVE: begin
        if (m_win == 0) m_go = 0;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("c", int'(bus.c), m_c);
      chk("go", int'(bus.go), m_go);
      chk("win", int'(bus.win), m_win);
      chk("cur_player", int'(cur_player), m_cur);
      chk("cur_pos", int'(cur_pos), m_pos[m_cur]);
      chk("card_pic", int'(card_pic), m_card);
    end
  end

  // Key that yields picture pic under the current seed; bit 3 keeps it nonzero.
  function automatic logic [3:0] key_for(input int pic);
    logic [2:0] low;
    low = 3'(pic ^ m_seed);
    return {1'b1, low};
  endfunction

  task automatic cyc(input state_e s, input logic [3:0] k);
    bus.M = s;
    bus.A = (s == ST_PICK);
    bus.B = (s == ST_MOVE);
    key   = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    state_e s;
    bus.M = ST_IDLE; bus.A = 1'b0; bus.B = 1'b0; bus.N = 2'd0;
    model_reset();
    #1 rst = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst cur_pos", int'(cur_pos), 0);
    chk("rst cur_player", int'(cur_player), 0);
    chk("rst go", int'(bus.go), 0);
    chk("rst win", int'(bus.win), 0);
    chk("rst card_pic", int'(card_pic), 0);
    chk("rst c", int'(bus.c), 0);
    rst = 1'b1;

    start = 1'b1;
    cyc(ST_IDLE, 4'd0);
    chk("c after 1 edge", int'(bus.c), 0);
    cyc(ST_IDLE, 4'd0);
    chk("c after 2 edges", int'(bus.c), 1);

    // Player 0 at tile 0; tile 1 shows picture 5.
    cyc(ST_PICK, key_for(5));
    chk("match go", int'(bus.go), 1);
    chk("match card_pic", int'(card_pic), 5);
    cyc(ST_JUDGE, 4'd0);
    chk("judge pos", int'(cur_pos), 1);
    chk("judge go held", int'(bus.go), 1);
    chk("judge win 1 step", int'(bus.win), 0);
    cyc(ST_MOVE, 4'd0);
    chk("move clears go", int'(bus.go), 0);
    cyc(ST_PICK, key_for(1));
    chk("second match go", int'(bus.go), 1);
    cyc(ST_JUDGE, 4'd0);
    chk("second pos", int'(cur_pos), 2);
    chk("win at 2 steps", int'(bus.win), 1);
    cyc(ST_MOVE, 4'd0);
    chk("win in move", int'(bus.win), 1);
    cyc(ST_END, 4'd0);
    chk("win in end", int'(bus.win), 1);
    cyc(ST_IDLE, 4'd0);
    chk("win cleared", int'(bus.win), 0);
    chk("pos reinit", int'(cur_pos), 0);

    cyc(ST_PICK, key_for(4));
    chk("miss go", int'(bus.go), 0);
    chk("miss card_pic", int'(card_pic), 4);
    cyc(ST_JUDGE, 4'd0);
    chk("miss no move", int'(cur_pos), 0);

    bus.N = 2'd3;
    cyc(ST_MISS, 4'd0);
    cyc(ST_MISS, 4'd0);
    chk("rot3 to 2", int'(cur_player), 2);
    cyc(ST_MISS, 4'd0);
    chk("rot3 wrap", int'(cur_player), 0);
    bus.N = 2'd0;
    repeat (3) cyc(ST_MISS, 4'd0);
    chk("rot4 to 3", int'(cur_player), 3);
    cyc(ST_MISS, 4'd0);
    chk("rot4 wrap", int'(cur_player), 0);
    repeat (3) cyc(ST_MISS, 4'd0);
    bus.N = 2'd2;
    cyc(ST_MISS, 4'd0);
    chk("N shrink wrap", int'(cur_player), 0);

    cyc(ST_IDLE, 4'd0);
    bus.N = 2'd0;
    repeat (3) cyc(ST_MISS, 4'd0);
    chk("p3 start pos", int'(cur_pos), 12);
    for (int i = 13; i <= 16; i++) begin
      cyc(ST_PICK, key_for(tile[i % 16]));
      cyc(ST_JUDGE, 4'd0);
    end
    chk("wrap pos", int'(cur_pos), 0);
    cyc(ST_PICK, key_for(5));
    chk("post-wrap match", int'(bus.go), 1);
    cyc(ST_PICK, key_for(3));
    chk("post-wrap miss", int'(bus.go), 0);
    cyc(ST_PICK, key_for(5));

    #2 rst = 1'b0;
    #1;
    chk("async rst go", int'(bus.go), 0);
    chk("async rst win", int'(bus.win), 0);
    chk("async rst player", int'(cur_player), 0);
    chk("async rst pos", int'(cur_pos), 0);
    chk("async rst card", int'(card_pic), 0);
    chk("async rst c", int'(bus.c), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 7) == 0) bus.N = 2'($urandom_range(0, 3));
      s = state_e'($urandom_range(0, 7));
      if (s == ST_IDLE && $urandom_range(0, 3) != 0) s = ST_PICK;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      cyc(s, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
